// File: rtl/avl_port_arbiter_if.sv
// Single-beat Avalon-MM command/response bundle shared by the two engines and the DDR3 port.
// The arbiter takes the slave side from each engine and the master side toward the controller.
interface avl_port_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              read;
  logic              write;
  logic              burstbegin;
  logic              waitrequest_n;
  logic              readdatavalid;

  modport master (
    output address, writedata, read, write, burstbegin,
    input  waitrequest_n, readdatavalid, readdata
  );

  modport slave (
    input  address, writedata, read, write,
    output waitrequest_n, readdatavalid, readdata
  );
endinterface

// File: rtl/avl_port_arbiter.sv
// Two-master round-robin arbiter with hold cap for the DDR3 Avalon port; read beats are routed
// back through an in-order tag FIFO. Optional stall watchdog: define AVL_ARB_WATCHDOG_EN.
module avl_port_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 128,
  parameter int MAX_PENDING = 8,
  parameter int MAX_HOLD    = 16,
  parameter int IDLE_LIMIT  = 64
) (
  input  logic                         iCLK,
  input  logic                         iRST_n,
  input  logic                         local_init_done,
  avl_port_arbiter_if.slave            m0,
  avl_port_arbiter_if.slave            m1,
  avl_port_arbiter_if.master           avl,
  output logic [1:0]                   arb_grant,
  output logic [$clog2(MAX_PENDING):0] arb_pending,
  output logic [1:0]                   arb_error
);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t          state_q, state_d;
  logic            last_q;
  logic [HW-1:0]   hold_q;
  logic [PW:0]     cnt_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            tag_q [MAX_PENDING];
  logic            err0_q;
  logic            sel0, sel1, req0, req1, gnt_rd, gnt_wr;
  logic            full, empty, accept, push, pop, orphan, head;
  logic            hold_hit, grant_chg, wd_trip;

  assign sel0  = (state_q == GNT0);
  assign sel1  = (state_q == GNT1);
  assign req0  = m0.read | m0.write;
  assign req1  = m1.read | m1.write;
  assign full  = (cnt_q == (PW+1)'(MAX_PENDING));
  assign empty = (cnt_q == '0);

  always_comb begin
    avl.address   = '0;
    avl.writedata = '0;
    gnt_rd        = 1'b0;
    gnt_wr        = 1'b0;
    if (sel0) begin
      avl.address   = m0.address;
      avl.writedata = m0.writedata;
      gnt_rd        = m0.read;
      gnt_wr        = m0.write;
    end else if (sel1) begin
      avl.address   = m1.address;
      avl.writedata = m1.writedata;
      gnt_rd        = m1.read;
      gnt_wr        = m1.write;
    end
  end

  assign avl.read         = gnt_rd & ~full;
  assign avl.write        = gnt_wr;
  assign avl.burstbegin   = avl.read | avl.write;
  assign m0.waitrequest_n = sel0 & avl.waitrequest_n & (~m0.read | ~full);
  assign m1.waitrequest_n = sel1 & avl.waitrequest_n & (~m1.read | ~full);

  assign accept = (avl.read | avl.write) & avl.waitrequest_n;
  assign push   = avl.read & avl.waitrequest_n;
  assign pop    = avl.readdatavalid & ~empty;
  assign orphan = avl.readdatavalid & empty;
  assign head   = tag_q[rd_ptr_q];

  assign m0.readdatavalid = pop & ~head;
  assign m1.readdatavalid = pop & head;
  assign m0.readdata      = avl.readdata;
  assign m1.readdata      = avl.readdata;

  // Cap counts the command being accepted now, so the grant moves after exactly MAX_HOLD accepts.
  assign hold_hit = (hold_q == HW'(MAX_HOLD)) | (accept & (hold_q == HW'(MAX_HOLD - 1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (local_init_done & (req0 | req1))
              state_d = (req0 & (~req1 | last_q)) ? GNT0 : GNT1;
      GNT0: if (~req0 & ~accept)                 state_d = req1 ? GNT1 : IDLE;
            else if (req1 & (hold_hit | wd_trip)) state_d = GNT1;
      GNT1: if (~req1 & ~accept)                 state_d = req0 ? GNT0 : IDLE;
            else if (req0 & (hold_hit | wd_trip)) state_d = GNT0;
      default: state_d = IDLE;
    endcase
  end

  assign grant_chg = (state_d != state_q);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      hold_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err0_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_chg && state_d == GNT0) last_q <= 1'b0;
      if (grant_chg && state_d == GNT1) last_q <= 1'b1;
      if (grant_chg)                                hold_q <= '0;
      else if (accept && hold_q != HW'(MAX_HOLD)) hold_q <= hold_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (orphan) err0_q <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) tag_q[wr_ptr_q] <= sel1;
  end

`ifdef AVL_ARB_WATCHDOG_EN
  localparam int WW = $clog2(IDLE_LIMIT + 1);
  logic [WW-1:0] wd_q;
  logic          err1_q;

  assign wd_trip = (wd_q == WW'(IDLE_LIMIT));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wd_q   <= '0;
      err1_q <= 1'b0;
    end else begin
      if (accept || grant_chg || wd_trip) wd_q <= '0;
      else if (gnt_rd || gnt_wr)          wd_q <= wd_q + 1'b1;
      if (wd_trip) err1_q <= 1'b1;
    end
  end

  assign arb_error = {err1_q, err0_q};
`else
  assign wd_trip   = 1'b0;
  assign arb_error = {1'b0, err0_q};
`endif

  assign arb_grant   = {sel1, sel0};
  assign arb_pending = cnt_q;
endmodule
